// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// The row-priority helper is shared so every user resolves multi-key columns identically.
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_e;

  // Index of the lowest-numbered active-low row; lower rows win on ties.
  function automatic logic [1:0] lowest_low_row(input logic [ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for asynchronous, pulled-up inputs.
// Resets to all-ones so an idle (released) keypad is seen during and after reset.
module key_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one column per slot, debounces a single key,
// and reports it as a one-cycle KEY_VALID pulse with a held row*4+col code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_BITS  = 10,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ROWS-1:0]   KEY_ROW,
  output logic [COLS-1:0]   KEY_COL,
  output logic              KEY_VALID,
  output logic [CODE_W-1:0] KEY_CODE,
  output logic              KEY_HELD
);

  localparam logic [3:0] DT_C = 4'(DEBOUNCE_TICKS);

  logic [ROWS-1:0] rows_s;

  key_sync #(
    .WIDTH(ROWS)
  ) u_row_sync (
    .clk (CLK),
    .srst(RST),
    .din (KEY_ROW),
    .dout(rows_s)
  );

  scan_state_e              state_q,     state_d;
  logic [SCAN_DIV_BITS-1:0] div_q,       div_d;
  logic [1:0]               col_q,       col_d;
  logic [1:0]               cand_row_q,  cand_row_d;
  logic [1:0]               cand_col_q,  cand_col_d;
  logic [3:0]               cnt_q,       cnt_d;
  logic [3:0]               rcnt_q,      rcnt_d;
  logic [COLS-1:0]          key_col_q,   key_col_d;
  logic                     key_valid_q, key_valid_d;
  logic [CODE_W-1:0]        key_code_q,  key_code_d;
  logic                     key_held_q,  key_held_d;

  logic       tick;
  logic       any_low;
  logic       cand_low;
  logic [1:0] low_row;
  logic [3:0] cnt_inc;
  logic [3:0] rcnt_inc;
  logic       accept;
  logic       advance;

  assign tick     = &div_q;
  assign any_low  = ~&rows_s;
  assign low_row  = lowest_low_row(rows_s);
  assign cand_low = ~rows_s[cand_row_q];
  assign cnt_inc  = cnt_q + 4'd1;
  assign rcnt_inc = rcnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q + 1'b1;
    col_d       = col_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    accept      = 1'b0;
    advance     = 1'b0;

    case (state_q)
      SCAN: begin
        if (tick) begin
          if (any_low) begin
            cand_row_d = low_row;
            cand_col_d = col_q;
            cnt_d      = 4'd1;
            if (DEBOUNCE_TICKS == 1) accept = 1'b1;
            else                     state_d = DEBOUNCE;
          end else begin
            advance = 1'b1;
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (cand_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DT_C) accept = 1'b1;
          end else begin
            cnt_d   = 4'd0;
            state_d = SCAN;
            advance = 1'b1;
          end
        end
      end

      HELD: begin
        if (tick) begin
          if (!cand_low) begin
            if (rcnt_inc == DT_C) begin
              key_held_d = 1'b0;
              rcnt_d     = 4'd0;
              state_d    = SCAN;
              advance    = 1'b1;
            end else begin
              rcnt_d = rcnt_inc;
            end
          end else begin
            rcnt_d = 4'd0;
          end
        end
      end

      default: state_d = SCAN;
    endcase

    // Counters are cleared on acceptance so they can never run past the threshold.
    if (accept) begin
      key_code_d  = {cand_row_d, cand_col_d};
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
      cnt_d       = 4'd0;
      rcnt_d      = 4'd0;
      state_d     = HELD;
    end

    if (advance) col_d = col_q + 2'd1;

    key_col_d = ~(4'b0001 << col_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= SCAN;
      div_q       <= '0;
      col_q       <= 2'd0;
      cand_row_q  <= 2'd0;
      cand_col_q  <= 2'd0;
      cnt_q       <= 4'd0;
      rcnt_q      <= 4'd0;
      key_col_q   <= 4'b1110;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      col_q       <= col_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      key_col_q   <= key_col_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
    end
  end

  assign KEY_COL   = key_col_q;
  assign KEY_VALID = key_valid_q;
  assign KEY_CODE  = key_code_q;
  assign KEY_HELD  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical 4x4 key matrix driven by random presses,
// checked every cycle against a per-slot behavioural model of scan/debounce/release.
module tb_keypad_scanner;

  localparam int SDB  = 3;
  localparam int DT   = 4;
  localparam int SLOT = 1 << SDB;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] KEY_ROW;
  logic [3:0] KEY_COL;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;
  logic       KEY_HELD;

  logic [15:0] keys = 16'h0;   // bit r*4+c set = key (row r, col c) pressed

  always #5 CLK = ~CLK;

  // Matrix wiring: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    KEY_ROW = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !KEY_COL[c]) KEY_ROW[r] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV_BITS (SDB),
    .DEBOUNCE_TICKS(DT)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .KEY_ROW  (KEY_ROW),
    .KEY_COL  (KEY_COL),
    .KEY_VALID(KEY_VALID),
    .KEY_CODE (KEY_CODE),
    .KEY_HELD (KEY_HELD)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, advanced once per column slot.
  int         m_mode;     // 0 scanning, 1 confirming a candidate, 2 key held
  int         m_col, m_cand_r, m_cand_c, m_streak, m_rel;
  logic [3:0] m_code;
  logic       m_held, m_pulse;

  task automatic model_reset();
    m_mode = 0; m_col = 0; m_streak = 0; m_rel = 0;
    m_code = 4'd0; m_held = 1'b0; m_pulse = 1'b0;
  endtask

  function automatic int first_row(input int c);
    for (int r = 0; r < 4; r++) if (keys[r*4+c]) return r;
    return -1;
  endfunction

  task automatic model_accept();
    m_code  = 4'(m_cand_r * 4 + m_cand_c);
    m_pulse = 1'b1;
    m_held  = 1'b1;
    m_mode  = 2;
    m_rel   = 0;
    $display("key event code=%0d t=%0t", m_code, $time);
  endtask

  task automatic model_tick();
    int r;
    case (m_mode)
      0: begin
        r = first_row(m_col);
        if (r >= 0) begin
          m_cand_r = r; m_cand_c = m_col; m_streak = 1;
          if (m_streak == DT) model_accept();
          else                m_mode = 1;
        end else begin
          m_col = (m_col + 1) % 4;
        end
      end
      1: begin
        if (keys[m_cand_r*4+m_cand_c]) begin
          m_streak++;
          if (m_streak == DT) model_accept();
        end else begin
          m_mode = 0; m_col = (m_col + 1) % 4;
        end
      end
      default: begin
        if (!keys[m_cand_r*4+m_cand_c]) begin
          m_rel++;
          if (m_rel == DT) begin
            m_held = 1'b0; m_mode = 0; m_col = (m_col + 1) % 4;
          end
        end else begin
          m_rel = 0;
        end
      end
    endcase
  endtask

  // One column slot; the last edge of the slot is the one acting on the tick.
  task automatic run_slot();
    logic [3:0] exp_col;
    for (int i = 0; i < SLOT; i++) begin
      @(posedge CLK);
      m_pulse = 1'b0;
      if (i == SLOT - 1) model_tick();
      #1;
      exp_col = ~(4'b0001 << m_col);
      check_eq("col",   KEY_COL,            exp_col);
      check_eq("valid", {3'b000, KEY_VALID}, {3'b000, m_pulse});
      check_eq("code",  KEY_CODE,           m_code);
      check_eq("held",  {3'b000, KEY_HELD},  {3'b000, m_held});
    end
  endtask

  task automatic run_slots(input int n);
    for (int k = 0; k < n; k++) run_slot();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    check_eq("rst_col",   KEY_COL,            4'b1110);
    check_eq("rst_valid", {3'b000, KEY_VALID}, 4'd0);
    check_eq("rst_code",  KEY_CODE,           4'd0);
    check_eq("rst_held",  {3'b000, KEY_HELD},  4'd0);
    @(posedge CLK); #1;
    model_reset();
    check_eq("rst2_col",  KEY_COL,            4'b1110);
    check_eq("rst2_held", {3'b000, KEY_HELD},  4'd0);
    RST = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    model_reset();

    // Reset and idle column walk.
    keys = 16'h0;
    do_reset();
    run_slots(5);

    // Clean press of key 9 (row 2, col 1), then release.
    keys = 16'h0200;
    run_slots(14);
    check_eq("press9_code", KEY_CODE, 4'd9);
    check_eq("press9_col",  KEY_COL,  4'b1101);
    check_eq("press9_held", {3'b000, KEY_HELD}, 4'd1);
    keys = 16'h0;
    run_slots(6);
    check_eq("release_held", {3'b000, KEY_HELD}, 4'd0);

    // Second press: key 0.
    keys = 16'h0001;
    run_slots(14);
    check_eq("press0_code", KEY_CODE, 4'd0);
    keys = 16'h0;
    run_slots(6);

    // Bounce on key 5: two detecting ticks, then released.
    keys = 16'h0020;
    for (int k = 0; k < 8 && m_mode != 1; k++) run_slot();
    run_slot();
    keys = 16'h0;
    run_slots(4);
    check_eq("bounce_code", KEY_CODE, 4'd0);

    // Rows 1 and 3 in col 2; then key 3 pressed during HELD is ignored.
    keys = 16'h4040;
    for (int k = 0; k < 16 && m_mode != 2; k++) run_slot();
    keys = keys | 16'h0008;
    run_slots(4);
    check_eq("multi_code", KEY_CODE, 4'd6);
    keys = 16'h0;
    run_slots(6);

    // Reset after two debounce ticks with the key still held.
    keys = 16'h0200;
    for (int k = 0; k < 12 && !(m_mode == 1 && m_streak == 2); k++) run_slot();
    do_reset();
    run_slots(14);
    check_eq("rearm_code", KEY_CODE, 4'd9);
    keys = 16'h0;
    run_slots(6);

    // Random presses, releases, bounces and occasional resets.
    for (int s = 0; s < 300; s++) begin
      sel = $urandom_range(0, 49);
      if (sel == 0) do_reset();
      else if (sel < 8)  keys = 16'h0;
      else if (sel < 14) keys = 16'h1 << $urandom_range(0, 15);
      else if (sel < 17) keys = keys | (16'h1 << $urandom_range(0, 15));
      run_slot();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix keypad scanner for the term-project board: the input-side counterpart of the multiplexed seven-segment driver. The display driver strobes digit commons and drives segment lines; this block strobes keypad columns and reads row lines back. It debounces one key at a time and delivers a one-cycle key event with a 4-bit code to the game logic that feeds the score display.

## Interface
- SCAN_DIV_BITS, default 10: column dwell is 2^SCAN_DIV_BITS cycles; legal range 3..16.
- DEBOUNCE_TICKS, default 4: consecutive matching samples needed to accept a press or a release; legal range 1..15.
- CLK  input  1  system clock; single clock domain.
- RST  input  1  reset, synchronous, active-high.
- KEY_ROW  input  4  keypad row lines, active-low (pulled up), asynchronous to CLK.
- KEY_COL  output  4  column strobes, one-cold, active-low.
- KEY_VALID  output  1  one-cycle pulse when a debounced press is accepted.
- KEY_CODE  output  4  code of the last accepted key, row*4 + col; holds between events.
- KEY_HELD  output  1  high from acceptance until the debounced release.

## Operation
- KEY_ROW passes through a 2-flop synchronizer (reset value 4'b1111) before any use.
- Free-running divider of SCAN_DIV_BITS bits; tick = divider all-ones (last cycle of a column slot). All sampling happens only on tick.
- Column index col[1:0]; KEY_COL = ~(1 << col).
- Pressed row on a tick = lowest-index zero bit of the synchronized rows; lower row wins on multiple keys in one column.
- States (shared encoding):
  - SCAN: on tick, if any row is low, latch cand_row/cand_col, set cnt=1, go DEBOUNCE, and keep col frozen. Otherwise col <= col+1 (wraps 3->0).
  - DEBOUNCE: on tick, if cand_row is still low, increment cnt. When cnt reaches DEBOUNCE_TICKS, go HELD. If cand_row is high, cnt=0, go SCAN, col <= col+1. If DEBOUNCE_TICKS==1, the latching tick in SCAN accepts immediately.
  - On acceptance: KEY_CODE <= {cand_row, cand_col}; KEY_VALID high for exactly one cycle; KEY_HELD <= 1.
  - HELD: col frozen. On tick, if cand_row is high, increment rcnt; if low, rcnt=0. When rcnt reaches DEBOUNCE_TICKS, KEY_HELD <= 0, rcnt=0, go SCAN, col <= col+1.
- Other keys pressed while in DEBOUNCE or HELD are ignored; there is no rollover and no auto-repeat.
- Counters cnt and rcnt are 4 bits and saturate conceptually at DEBOUNCE_TICKS; they never wrap.

## Timing
- Reset values: KEY_COL=4'b1110, KEY_VALID=0, KEY_CODE=4'h0, KEY_HELD=0, state SCAN, divider/cnt/rcnt=0, col=0.
- RST asserted mid-operation (any state) returns all of the above on the next edge. A press held through reset is re-detected from SCAN.
- KEY_COL changes in the cycle after a tick. Rows therefore settle for 2^SCAN_DIV_BITS−1 cycles, which exceeds the 2-cycle synchronizer delay.
- Accept latency: KEY_VALID and the new KEY_CODE appear on the edge of the DEBOUNCE_TICKS-th confirming tick (first detection counts as 1), registered, so they are visible the cycle after that tick.
- Release latency: KEY_HELD falls DEBOUNCE_TICKS release ticks after the first high sample.
- A bounce (row high on any tick in DEBOUNCE) produces no KEY_VALID and leaves KEY_CODE unchanged.

## Structure
- Package keypad_pkg: state enum (SCAN, DEBOUNCE, HELD), ROWS=4, COLS=4, CODE_W=4.
- Sub-module key_sync: 2-flop synchronizer, width parameter, reset value all-ones. Used once for KEY_ROW.
- Divider, FSM and counters live in keypad_scanner.

## Test plan
- Reset: drive RST for 2 cycles with KEY_ROW=4'b1111 -> KEY_COL=4'b1110 and outputs 0. Then KEY_COL walks 1110→1101→1011→0111→1110, one step per 8 cycles (SCAN_DIV_BITS=3).
- Clean press, DEBOUNCE_TICKS=4: model row 2 pulled low only while col 1 is strobed, held 100 cycles -> one KEY_VALID pulse with KEY_CODE=4'd9, KEY_HELD=1, KEY_COL stays 1101. Pulse arrives exactly 3 ticks (24 cycles) after the detecting tick.
- Bounce: row low for 2 ticks, then high -> no KEY_VALID, KEY_CODE unchanged, scanning resumes at the next column.
- Release: after the clean press, release the key -> KEY_HELD falls 4 ticks after the first high sample. A second press of key 0 (row0, col0) then gives KEY_CODE=4'd0.
- Multi-key: rows 1 and 3 low in col 2 -> KEY_CODE=4'd6. A simultaneous press in col 3 during HELD is ignored.
- Reset mid-DEBOUNCE after 2 ticks -> outputs at reset values, no KEY_VALID. Key still held -> accepted again 3 ticks after its next detection.
